// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1/8E1/8O1/8x2 UART transmit serializer with TI done pulse and sticky overrun
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DIVISOR   = CLK_FREQ / BAUD,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       WR,
  input  logic [7:0] din,
  output logic       txd,
  output logic       TI,
  output logic       busy,
  output logic       ovr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(DIVISOR - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        PAR_EN    = (PARITY != 0);
  localparam logic        PAR_ODD   = (PARITY == 2);

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift_reg, shift_reg_nxt;
  logic        parity_bit, parity_bit_nxt;
  logic        txd_nxt, ti_nxt, ovr_nxt;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      TI         <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift_reg  <= shift_reg_nxt;
      parity_bit <= parity_bit_nxt;
      txd        <= txd_nxt;
      TI         <= ti_nxt;
      ovr        <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    baud_cnt_nxt   = baud_cnt + 16'd1;
    bit_idx_nxt    = bit_idx;
    shift_reg_nxt  = shift_reg;
    parity_bit_nxt = parity_bit;
    ti_nxt         = 1'b0;
    ovr_nxt        = ovr | (WR & busy);

    case (state)
      S_IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        if (WR) begin
          shift_reg_nxt  = din;
          parity_bit_nxt = (^din) ^ PAR_ODD;
          state_nxt      = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_nxt  = '0;
          shift_reg_nxt = {1'b0, shift_reg[7:1]};
          bit_idx_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            bit_idx_nxt = '0;
            state_nxt   = PAR_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = S_IDLE;
            ti_nxt      = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
      end
    endcase

    // Line level follows the state being entered so txd stays a pure register.
    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shift_reg_nxt[0];
      S_PARITY: txd_nxt = parity_bit_nxt;
      default:  txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- 8-bit UART transmit serializer: start bit, 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
- Sits directly downstream of control_fifo and consumes its WR strobe plus the FIFO read data.
- Drives the board TXD pin.
- Returns the TI (transmit-done) pulse that control_fifo uses to issue the next FIFO read.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz (50 MHz, 20 ns period).
- BAUD, 9600, line rate in bit/s.
- DIVISOR, CLK_FREQ/BAUD (5208 with defaults), clock cycles per bit. Integer division, truncated. Legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- WR  in  1  one-cycle write strobe from control_fifo; din is valid in the same cycle.
- din  in  8  byte to transmit.
- txd  out  1  serial line; idles high.
- TI  out  1  one-cycle pulse marking the end of the last stop bit.
- busy  out  1  high while a frame is in progress.
- ovr  out  1  sticky overrun flag: a WR arrived while busy.

Interface (already decided):
- Single clock domain, clock = `clock`.
- Reset `rst` is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: txd=1, TI=0, busy=0, ovr=0.
  - State: IDLE; bit counter and baud counter cleared.
  - Applies mid-frame too: the frame is abandoned, no TI pulse, txd returns high the next cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1, busy=0. WR=1 at edge n does the following:
  - din is latched into the shift register.
  - State goes to START.
  - txd=0 and busy=1 from cycle n+1.
  - Latency from WR to start bit is exactly 1 cycle.
- Baud counter:
  - Counts 0..DIVISOR-1.
  - Every bit, including start, parity and stop, lasts exactly DIVISOR cycles.
  - The counter is reloaded to 0 on every state or bit transition; it does not run free.
- START: after DIVISOR cycles go to DATA, bit index 0.
- DATA:
  - txd = shift_reg[0].
  - At each bit end, shift right and increment the index.
  - After bit 7, go to PARITY if PARITY!=0, otherwise to STOP.
- PARITY:
  - txd = XOR of the 8 latched bits for even parity; inverted XOR for odd parity.
  - Lasts one bit time.
- STOP:
  - txd=1 for STOP_BITS*DIVISOR cycles, then return to IDLE.
  - TI=1 for exactly one cycle: the first IDLE cycle, with busy=0 in that cycle.
- Frame length from the first start-bit cycle to the TI cycle: DIVISOR*(10 + (PARITY!=0) + (STOP_BITS-1)) cycles.
- Back-to-back:
  - WR in the same cycle TI=1 is accepted.
  - The next start bit begins on the following cycle, so there is no idle gap beyond the TI cycle.
- WR while busy=1:
  - The byte is dropped.
  - ovr is set and held until rst.
  - The current frame is unaffected.
- din is sampled only on an accepted WR; changes to din mid-frame have no effect.
- TI never asserts without a preceding accepted WR.
- TI is never asserted for more than 1 cycle.
- txd is registered, with no combinational path from WR or din.

Test Plan:
- Line check:
  - Setup: DIVISOR=16, PARITY=0, STOP_BITS=1; rst for 3 cycles, then WR with din=8'hA5.
  - Required: txd low cycles 1-16; data bits 1,0,1,0,0,1,0,1 at 16 cycles each; high cycles 145-160.
  - Required: TI=1 only at cycle 161, busy=0 there.
- Back-to-back:
  - Stimulus: WR din=8'h55, then WR din=8'h0F asserted in the TI cycle.
  - Required: second start bit begins on the cycle after TI; both frames decode correctly with a sampling model; exactly 2 TI pulses.
- Overrun:
  - Stimulus: WR din=8'h3C, then WR din=8'hFF at cycle 40.
  - Required: ovr=1 from cycle 41 and it stays set; transmitted byte decodes as 8'h3C; only one TI pulse.
- Parity and stop bits:
  - Setup: PARITY=1 with din=8'h07, expect parity bit 1.
  - Setup: PARITY=2 with din=8'h07, expect parity bit 0.
  - Setup: STOP_BITS=2, expect stop high for 32 cycles.
  - Required: TI at cycle 177 for PARITY!=0 with STOP_BITS=1.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3.
  - Required: next cycle txd=1, busy=0, ovr=0; no TI pulse; a subsequent WR with 8'h81 transmits cleanly.
- Integration with control_fifo:
  - Setup: defaults (DIVISOR=5208).
  - Stimulus: FIFO model holding 3 bytes, en pulsed.
  - Required: three consecutive frames of 52080 cycles each; each TI triggers the next rinc/WR; txd stays high after the FIFO empties.
